// File: rtl/rpn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rpn_pkg                                                   |
// | Purpose  : Shared opcode and FSM state encodings for the RPN         |
// |            token sequencer.                                          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rpn_pkg;

    localparam int OP_BITS    = 2;
    localparam int STATE_BITS = 3;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } opcode_t;

    typedef logic [STATE_BITS-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_PUSH     = 3'd1;
    localparam state_t ST_POP_B    = 3'd2;
    localparam state_t ST_WAIT_B   = 3'd3;
    localparam state_t ST_POP_A    = 3'd4;
    localparam state_t ST_WAIT_A   = 3'd5;
    localparam state_t ST_EXEC     = 3'd6;
    localparam state_t ST_PUSH_RES = 3'd7;

endpackage : rpn_pkg
`default_nettype wire

// File: rtl/rpn_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rpn_alu                                                   |
// | Purpose  : Combinational ALU for the RPN sequencer (y = a op b).     |
// |            RPN_SAT_EN makes ADD/SUB saturate instead of wrapping.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WORD_BITS = 4
) (
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b,
    input  opcode_t              op,
    output logic [WORD_BITS-1:0] y
);

`ifdef RPN_SAT_EN
    // Extra MSB carries the carry/borrow used to pick the saturation value
    logic [WORD_BITS:0] w_sum;
    logic [WORD_BITS:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD: y = w_sum[WORD_BITS]  ? {WORD_BITS{1'b1}} : w_sum[WORD_BITS-1:0];
            OP_SUB: y = w_diff[WORD_BITS] ? {WORD_BITS{1'b0}} : w_diff[WORD_BITS-1:0];
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end
`else
    logic [WORD_BITS-1:0] w_sum;
    logic [WORD_BITS-1:0] w_diff;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD: y = w_sum;
            OP_SUB: y = w_diff;
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end
`endif

endmodule : rpn_alu
`default_nettype wire

// File: rtl/rpn_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rpn_seq                                                   |
// | Purpose  : RPN token sequencer driving an external LIFO stack;       |
// |            tracks occupancy and rejects over/underflowing tokens.    |
// |            Optional macro RPN_SAT_EN: saturating ADD/SUB.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rpn_seq
    import rpn_pkg::*;
#(
    parameter int WORD_BITS = 4,
    parameter int ADRS_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic                 tok_is_op,
    input  logic [WORD_BITS-1:0] tok_data,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [WORD_BITS-1:0] stk_push_data,
    input  logic [WORD_BITS-1:0] stk_pop_data,
    output logic [WORD_BITS-1:0] result,
    output logic                 result_valid,
    output logic                 err_ovf,
    output logic                 err_unf,
    output logic [ADRS_BITS:0]   count
);

    localparam int DEPTH = 2 ** ADRS_BITS;

    localparam logic [ADRS_BITS:0] c_DEPTH = (ADRS_BITS + 1)'(DEPTH);
    localparam logic [ADRS_BITS:0] c_TWO   = (ADRS_BITS + 1)'(2);

    state_t               r_state;
    state_t               w_next;
    logic [ADRS_BITS:0]   r_count;
    logic [WORD_BITS-1:0] r_opnd;
    logic [WORD_BITS-1:0] r_a;
    logic [WORD_BITS-1:0] r_b;
    logic [WORD_BITS-1:0] r_result;
    opcode_t              r_op;
    logic                 r_err_ovf;
    logic                 r_err_unf;

    logic                 w_accept;
    logic                 w_full;
    logic                 w_few;
    logic [WORD_BITS-1:0] w_alu_y;

    assign tok_ready = (r_state == ST_IDLE);
    assign w_accept  = tok_valid & tok_ready;
    assign w_full    = (r_count == c_DEPTH);
    assign w_few     = (r_count < c_TWO);

    rpn_alu #(
        .WORD_BITS (WORD_BITS)
    ) u_alu (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .y  (w_alu_y)
    );

    // Rejected tokens leave the FSM in IDLE so no stack request is ever issued
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (tok_is_op) begin
                        if (!w_few) w_next = ST_POP_B;
                    end else begin
                        if (!w_full) w_next = ST_PUSH;
                    end
                end
            end
            ST_PUSH:     w_next = ST_IDLE;
            ST_POP_B:    w_next = ST_WAIT_B;
            ST_WAIT_B:   w_next = ST_POP_A;
            ST_POP_A:    w_next = ST_WAIT_A;
            ST_WAIT_A:   w_next = ST_EXEC;
            ST_EXEC:     w_next = ST_PUSH_RES;
            ST_PUSH_RES: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_opnd    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_op      <= OP_ADD;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_err_ovf <= w_accept & ~tok_is_op & w_full;
            r_err_unf <= w_accept &  tok_is_op & w_few;

            if (w_accept && !tok_is_op) r_opnd <= tok_data;
            if (w_accept &&  tok_is_op) r_op   <= opcode_t'(tok_data[OP_BITS-1:0]);

            // Popped word arrives one cycle after the pop strobe
            if (r_state == ST_WAIT_B) r_b      <= stk_pop_data;
            if (r_state == ST_WAIT_A) r_a      <= stk_pop_data;
            if (r_state == ST_EXEC)   r_result <= w_alu_y;

            // Count mirrors the real stack occupancy strobe by strobe
            case (r_state)
                ST_PUSH, ST_PUSH_RES: r_count <= r_count + 1'b1;
                ST_POP_B, ST_POP_A:   r_count <= r_count - 1'b1;
                default:              r_count <= r_count;
            endcase
        end
    end

    assign stk_push      = (r_state == ST_PUSH) || (r_state == ST_PUSH_RES);
    assign stk_pop       = (r_state == ST_POP_B) || (r_state == ST_POP_A);
    assign stk_push_data = (r_state == ST_PUSH_RES) ? r_result : r_opnd;
    assign result        = r_result;
    assign result_valid  = (r_state == ST_PUSH_RES);
    assign err_ovf       = r_err_ovf;
    assign err_unf       = r_err_unf;
    assign count         = r_count;

endmodule : rpn_seq
`default_nettype wire
